// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state enum and default frame parameters.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_BIT_CYCLES = 13024;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period generator for the UART transmitter: a 0..BIT_CYCLES-1 counter
// with synchronous restart, emitting a one-cycle bit_tick_o at terminal count.
module uart_tx_baud_gen
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = UART_BIT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic enable_i,
  output logic bit_tick_o
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = enable_i && !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: valid/ready byte intake, 8N1 serialisation on tx_o.
// Define UART_TX_PARITY_EN to append an even parity bit (11-bit frame).
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = UART_BIT_CYCLES,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 accept;
  logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign accept = (state_q == TX_IDLE) && tx_valid_i;

  uart_tx_baud_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .restart_i  (accept),
    .enable_i   (state_q != TX_IDLE),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      TX_IDLE: begin
        if (tx_valid_i) begin
          shift_d   = tx_data_i;
          bit_cnt_d = '0;
          state_d   = TX_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data_i;
`endif
        end
      end
      TX_START: begin
        if (bit_tick) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_tick) state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (bit_tick) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // tx_o is registered, so its next level is decoded from the next state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = (state_q == TX_IDLE);
  assign busy_o     = (state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at BIT_CYCLES=16; expected line
// levels come from a frame model built with plain arithmetic on the byte.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int BITC = 16;
  localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit HAS_PARITY = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit HAS_PARITY = 1'b0;
`endif
  localparam int FRAME_CYCLES = FRAME_BITS * BITC;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       tx_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(
    .BIT_CYCLES(BITC),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .tx_o       (tx_o),
    .busy_o     (busy_o)
  );

  always #4 clk_i = ~clk_i;

  // Level of frame bit idx: start, data LSB first, optional even parity, stop.
  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DATA_BITS) return logic'((int'(d) >> (idx - 1)) % 2);
    if (HAS_PARITY && idx == DATA_BITS + 1) return logic'($countones(d) % 2);
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_tx"}, tx_o, 1'b1);
    checkOutput({tag, "_ready"}, tx_ready_o, 1'b1);
    checkOutput({tag, "_busy"}, busy_o, 1'b0);
  endtask

  // Waits (bounded) for ready, presents the byte and returns 1ns after the accept edge.
  task automatic applyStimulus(input logic [7:0] d, input bit holdValid);
    int n = 0;
    while (tx_ready_o !== 1'b1 && n < 1000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n == 1000) begin
      checks++;
      errors++;
      $error("[TB] FAIL ready_timeout observed=%b expected=1", tx_ready_o);
    end
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(posedge clk_i); #1;
    if (!holdValid) tx_valid_i = 1'b0;
  endtask

  // Checks a whole frame cycle by cycle starting 1ns after its accept edge.
  task automatic checkFrame(input logic [7:0] d, input int changeAt, input int abortAt);
    for (int t = 0; t < FRAME_CYCLES; t++) begin
      if (t == abortAt) begin
        rst_i = 1'b1;
        #1;
        checkIdle("abort");
        repeat (3) @(posedge clk_i);
        #1;
        checkIdle("abort_hold");
        rst_i = 1'b0;
        for (int c = 0; c < 2 * BITC; c++) begin
          @(posedge clk_i); #1;
          checkOutput("post_abort_tx", tx_o, 1'b1);
          checkOutput("post_abort_ready", tx_ready_o, 1'b1);
        end
        return;
      end
      checkOutput("frame_tx", tx_o, frameBit(d, t / BITC));
      checkOutput("frame_ready", tx_ready_o, 1'b0);
      checkOutput("frame_busy", busy_o, 1'b1);
      if (t == changeAt) tx_data_i = 8'h3C;
      @(posedge clk_i); #1;
    end
    checkIdle("frame_end");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] r;
    rst_i      = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    #2;
    checkIdle("reset");
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int c = 0; c < 3 * BITC; c++) begin
      @(posedge clk_i); #1;
      checkOutput("idle_tx", tx_o, 1'b1);
      checkOutput("idle_ready", tx_ready_o, 1'b1);
    end

    $display("[TB] frame 0xA5");
    applyStimulus(8'hA5, 1'b0);
    checkFrame(8'hA5, -1, -1);

    $display("[TB] parity-sensitive frame 0x07");
    applyStimulus(8'h07, 1'b0);
    checkFrame(8'h07, -1, -1);

    $display("[TB] back-to-back 0x00 then 0xFF");
    applyStimulus(8'h00, 1'b1);
    tx_data_i = 8'hFF;
    checkFrame(8'h00, -1, -1);
    @(posedge clk_i); #1;
    tx_valid_i = 1'b0;
    checkFrame(8'hFF, -1, -1);

    $display("[TB] data change while busy");
    applyStimulus(8'h5A, 1'b0);
    checkFrame(8'h5A, 3 * BITC + 2, -1);
    repeat (BITC) @(posedge clk_i);
    #1;
    checkIdle("no_spurious_frame");

    $display("[TB] reset during data bit 3");
    r = 8'($urandom_range(0, 255));
    applyStimulus(r, 1'b0);
    checkFrame(r, -1, 4 * BITC + 5);
    applyStimulus(8'h81, 1'b0);
    checkFrame(8'h81, -1, -1);

    $display("[TB] random frames");
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 5)) @(posedge clk_i);
      #1;
      applyStimulus(r, 1'b0);
      checkFrame(r, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
